// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit registered ALU: widths, opcodes, shift modes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_pkg;

    localparam int ALU_WIDTH = 16;
    localparam int ALU_SHW   = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_RL  = 3'b111;

    // Shift mode is op[1:0] of the shift opcodes, so the top passes it straight through.
    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_RL  = 2'b11
    } shift_mode_t;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter: SLL / SRL / SRA / rotate-left by imm.
// Latency: 0 cycles (pure combinational, log2 stages of 1,2,4,8...).
// Backpressure: none; output follows inputs.
//
// Ports:
//   a    - source operand
//   imm  - shift/rotate amount
//   mode - SH_SLL, SH_SRL, SH_SRA or SH_RL
//   res  - shifted/rotated result
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SHW   = ALU_SHW
) (
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   imm,
    input  shift_mode_t      mode,
    output logic [WIDTH-1:0] res
);

    // stage[k] is the value after applying imm bits below k.
    logic [SHW:0][WIDTH-1:0] stage;

    assign stage[0] = a;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int AMT = 1 << k;
        logic [WIDTH-1:0] shifted;

        always_comb begin
            shifted = stage[k];
            unique case (mode)
                SH_SLL: shifted = stage[k] << AMT;
                SH_SRL: shifted = stage[k] >> AMT;
                // Sign bit survives each stage, so cascading arithmetic shifts stays sign-filled.
                SH_SRA: shifted = $unsigned($signed(stage[k]) >>> AMT);
                SH_RL:  shifted = (stage[k] << AMT) | (stage[k] >> (WIDTH - AMT));
                default: shifted = stage[k];
            endcase
        end

        assign stage[k+1] = imm[k] ? shifted : stage[k];
    end

    assign res = stage[SHW];

endmodule

// File: rtl/alu.sv
// Registered 16-bit ALU: add/sub/and/or plus barrel shifts, with zero/neg/ovf flags.
// Latency: 1 cycle; inputs sampled at edge N appear on out/flags after edge N.
// Backpressure: none; a new op is accepted every cycle.
//
// Ports:
//   clk, rst       - rising-edge clock, async active-high reset
//   A, B           - operands (B unused for shift ops)
//   op             - operation select (see alu_pkg opcodes)
//   imm            - shift/rotate amount (unused for arithmetic/logic ops)
//   out            - registered result
//   zero, neg, ovf - registered flags of the result
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SHW   = ALU_SHW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    input  logic [SHW-1:0]   imm,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] sh_res;
    logic [WIDTH-1:0] res;
    logic             ovf_nxt;
    shift_mode_t      sh_mode;

    // Carry-out is intentionally dropped: results wrap mod 2^WIDTH.
    assign sum  = A + B;
    assign diff = A - B;

    assign sh_mode = shift_mode_t'(op[1:0]);

    alu_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .a    (A),
        .imm  (imm),
        .mode (sh_mode),
        .res  (sh_res)
    );

    always_comb begin
        res     = '0;
        ovf_nxt = 1'b0;
        unique case (op)
            OP_ADD: begin
                res     = sum;
                // Same-sign operands producing a different-sign sum.
                ovf_nxt = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                res     = diff;
                // Opposite-sign operands producing a result whose sign differs from A.
                ovf_nxt = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  res = A & B;
            OP_OR:   res = A | B;
            default: res = sh_res;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out  <= '0;
            zero <= 1'b1;
            neg  <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            out  <= res;
            zero <= (res == '0);
            neg  <= res[WIDTH-1];
            ovf  <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_alu.sv
module tb_alu;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] A;
    logic [15:0] B;
    logic [2:0]  op;
    logic [3:0]  imm;
    logic [15:0] out;
    logic        zero;
    logic        neg;
    logic        ovf;

    int n_cmp;
    int n_err;

    alu dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .op   (op),
        .imm  (imm),
        .out  (out),
        .zero (zero),
        .neg  (neg),
        .ovf  (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: arithmetic on plain signed/unsigned integers. Returns {ovf, result}.
    function automatic logic [16:0] model(input logic [2:0] o, input logic [15:0] a,
                                          input logic [15:0] b, input logic [3:0] n);
        int ua, ub, sa, sb, s, r;
        logic v;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 32768) ? ua - 65536 : ua;
        sb = (ub >= 32768) ? ub - 65536 : ub;
        v  = 1'b0;
        r  = 0;
        case (o)
            3'd0: begin s = sa + sb; r = ua + ub; v = (s > 32767) || (s < -32768); end
            3'd1: begin s = sa - sb; r = ua - ub; v = (s > 32767) || (s < -32768); end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua << n;
            3'd5: r = ua >> n;
            3'd6: r = sa >>> n;
            default: r = (ua << n) | (ua >> (16 - int'(n)));
        endcase
        return {v, r[15:0]};
    endfunction

    // Drive one op at the falling edge, then check all outputs just after the rising edge.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [15:0] a,
                          input logic [15:0] b, input logic [3:0] n);
        logic [16:0] m;
        @(negedge clk);
        op = o; A = a; B = b; imm = n;
        m = model(o, a, b, n);
        @(posedge clk);
        #1;
        chk({tag, ".out"},  32'(out),  32'(m[15:0]));
        chk({tag, ".zero"}, 32'(zero), 32'(m[15:0] == 16'h0));
        chk({tag, ".neg"},  32'(neg),  32'(m[15]));
        chk({tag, ".ovf"},  32'(ovf),  32'(m[16]));
    endtask

    typedef struct {
        string       tag;
        logic [2:0]  o;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  n;
        logic [15:0] want;
        logic        want_ovf;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [16:0] m;
        logic [15:0] held;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1; A = '0; B = '0; op = OP_ADD; imm = '0;

        #1;
        chk("rst.out",  32'(out),  32'h0);
        chk("rst.zero", 32'(zero), 32'h1);
        chk("rst.neg",  32'(neg),  32'h0);
        chk("rst.ovf",  32'(ovf),  32'h0);

        @(negedge clk);
        rst = 1'b0;
        run_op("add1p1", OP_ADD, 16'h0001, 16'h0001, 4'd0);
        chk("add1p1.const", 32'(out), 32'h0002);

        // Async reset mid-cycle clears immediately, and discards the op pending at the next edge.
        run_op("pre_rst", OP_OR, 16'h1234, 16'h8000, 4'd0);
        @(negedge clk);
        op = OP_ADD; A = 16'h7fff; B = 16'h0001;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst.out",  32'(out),  32'h0);
        chk("midrst.zero", 32'(zero), 32'h1);
        chk("midrst.neg",  32'(neg),  32'h0);
        @(posedge clk);
        #1;
        chk("heldrst.out", 32'(out), 32'h0);
        chk("heldrst.ovf", 32'(ovf), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_op("post_rst", OP_ADD, 16'h0001, 16'h0001, 4'd0);
        chk("post_rst.const", 32'(out), 32'h0002);

        // Directed cases, each also checked against a hand-computed constant.
        vecs.push_back('{"add_wrap",  OP_ADD, 16'hfff9, 16'h0007, 4'd0,  16'h0000, 1'b0});
        vecs.push_back('{"sub",       OP_SUB, 16'h0007, 16'hfff9, 4'd0,  16'h000e, 1'b0});
        vecs.push_back('{"add_ovf",   OP_ADD, 16'h7fff, 16'h0001, 4'd0,  16'h8000, 1'b1});
        vecs.push_back('{"sub_ovf",   OP_SUB, 16'h8000, 16'h0001, 4'd0,  16'h7fff, 1'b1});
        vecs.push_back('{"and",       OP_AND, 16'h89ab, 16'hfedc, 4'd0,  16'h8888, 1'b0});
        vecs.push_back('{"or",        OP_OR,  16'h89ab, 16'hfedc, 4'd0,  16'hffff, 1'b0});
        vecs.push_back('{"sll15",     OP_SLL, 16'h789a, 16'h1111, 4'd15, 16'h0000, 1'b0});
        vecs.push_back('{"srl15",     OP_SRL, 16'h789a, 16'h2222, 4'd15, 16'h0000, 1'b0});
        vecs.push_back('{"sra15",     OP_SRA, 16'h8054, 16'h3333, 4'd15, 16'hffff, 1'b0});
        vecs.push_back('{"rl15",      OP_RL,  16'h8754, 16'h4444, 4'd15, 16'h43aa, 1'b0});
        vecs.push_back('{"sll0",      OP_SLL, 16'ha5c3, 16'h0000, 4'd0,  16'ha5c3, 1'b0});
        vecs.push_back('{"srl0",      OP_SRL, 16'ha5c3, 16'h0000, 4'd0,  16'ha5c3, 1'b0});
        vecs.push_back('{"sra0",      OP_SRA, 16'ha5c3, 16'h0000, 4'd0,  16'ha5c3, 1'b0});
        vecs.push_back('{"rl0",       OP_RL,  16'ha5c3, 16'h0000, 4'd0,  16'ha5c3, 1'b0});
        vecs.push_back('{"sra_pos",   OP_SRA, 16'h7000, 16'hffff, 4'd4,  16'h0700, 1'b0});
        vecs.push_back('{"rl1",       OP_RL,  16'h8001, 16'h0000, 4'd1,  16'h0003, 1'b0});
        vecs.push_back('{"sll4",      OP_SLL, 16'h1234, 16'h0000, 4'd4,  16'h2340, 1'b0});
        vecs.push_back('{"srl4",      OP_SRL, 16'h8234, 16'h0000, 4'd4,  16'h0823, 1'b0});
        foreach (vecs[i]) begin
            run_op(vecs[i].tag, vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].n);
            chk({vecs[i].tag, ".const"},     32'(out), 32'(vecs[i].want));
            chk({vecs[i].tag, ".const_ovf"}, 32'(ovf), 32'(vecs[i].want_ovf));
        end

        // B wiggling during a shift op must not affect the result.
        @(negedge clk);
        op = OP_SLL; A = 16'h1234; B = 16'h0000; imm = 4'd3;
        #2;
        B = 16'($urandom);
        @(posedge clk);
        #1;
        chk("shift_b_wiggle", 32'(out), 32'h91a0);
        held = out;

        // Inputs changing after the edge leave out untouched until the next edge.
        A = 16'hffff; op = OP_ADD; B = 16'h0001;
        #2;
        chk("midcycle_hold", 32'(out), 32'(held));

        // Back-to-back: every op, one per cycle, no bubbles.
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("b2b%0d", i), 3'(i), 16'($urandom), 16'($urandom), 4'($urandom));
        end

        // Randomised sweep against the reference model.
        for (int i = 0; i < 300; i++) begin
            run_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), 16'($urandom),
                   16'($urandom), 4'($urandom));
        end

        // Edge-biased operands (sign boundaries) for the overflow logic.
        for (int i = 0; i < 40; i++) begin
            logic [15:0] ea, eb;
            ea = (i % 2 == 0) ? 16'h7fff - 16'($urandom_range(0, 3)) : 16'h8000 + 16'($urandom_range(0, 3));
            eb = (i % 4 < 2)  ? 16'($urandom_range(0, 3))            : 16'hffff - 16'($urandom_range(0, 3));
            run_op($sformatf("edge%0d", i), 3'($urandom_range(0, 1)), ea, eb, 4'd0);
        end

        m = model(OP_ADD, 16'h0, 16'h0, 4'd0);
        run_op("final_zero", OP_ADD, 16'h0, 16'h0, 4'd0);
        chk("final_zero.const", 32'(zero), 32'(m[15:0] == 16'h0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
16-bit registered arithmetic/logic unit for the lab datapath execute stage. Performs add, subtract, AND, OR and immediate-count shifts/rotate on operands A/B. Result and status flags are registered on the rising clock edge, one cycle after inputs are applied.

Parameters:
WIDTH, 16, data width of A, B and out.
SHW, 4, width of imm shift amount (log2 WIDTH).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous active-high reset.
A  input  WIDTH  operand A; the shifted/rotated source for shift ops.
B  input  WIDTH  operand B; ignored for op[2]=1.
op  input  3  operation select.
imm  input  SHW  shift/rotate amount, 0..15; ignored for op[2]=0.
out  output  WIDTH  registered result.
zero  output  1  registered: result == 0.
neg  output  1  registered: result[WIDTH-1].
ovf  output  1  registered: signed overflow for ADD/SUB; 0 for all other ops.

Behaviour:
- Reset: rst high asynchronously forces out=0, zero=1, neg=0, ovf=0. These values are held while rst is high. The first capture occurs at the first rising clk edge after rst deasserts.
- Latency: combinational result from inputs sampled at edge N appears on out/flags after edge N. There is no handshake; a new op is accepted every cycle.
- Op encoding:
  - 000 ADD: A+B mod 2^16.
  - 001 SUB: A-B mod 2^16 (two's complement).
  - 010 AND: A&B.
  - 011 OR: A|B.
  - 100 SLL: A << imm, zero fill.
  - 101 SRL: A >> imm, zero fill.
  - 110 SRA: A >>> imm, sign fill from A[15].
  - 111 RL: rotate A left by imm; bits leaving MSB re-enter at LSB.
- Width rules:
  - Carry-out is discarded.
  - imm=0 gives out=A for all shift ops.
  - imm=15 is the maximum shift.
  - RL by 15 equals rotate right by 1.
- ovf:
  - ADD: ovf = (A[15]==B[15]) && (sum[15]!=A[15]).
  - SUB: ovf = (A[15]!=B[15]) && (diff[15]!=A[15]).
- Inputs changing mid-cycle do not affect out until the next edge.
- Reset asserted mid-operation discards the pending result.

Decomposition:
- Shared package alu_pkg:
  - opcode constants OP_ADD=3'b000, OP_SUB=3'b001, OP_AND=3'b010, OP_OR=3'b011, OP_SLL=3'b100, OP_SRL=3'b101, OP_SRA=3'b110, OP_RL=3'b111.
  - WIDTH/SHW defaults.
- One sub-module alu_shifter: purely combinational barrel shifter.
  - Inputs: A, imm, 2-bit mode (SLL/SRL/SRA/RL).
  - Implemented as 4 log stages (1,2,4,8).
- Adder/subtractor, logic ops, result mux and flag registers live in alu.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> out=0x0000, zero=1, neg=0, ovf=0 immediately; release, apply ADD 1+1 -> out=0x0002 after next edge.
- Arithmetic:
  - ADD A=0xfff9 B=0x0007 -> out=0x0000, zero=1, ovf=0.
  - SUB A=0x0007 B=0xfff9 -> out=0x000E, ovf=0.
  - ADD 0x7fff+0x0001 -> out=0x8000, ovf=1, neg=1.
- Logic:
  - AND A=0x89ab B=0xfedc -> out=0x8888, neg=1.
  - OR same operands -> out=0xffff.
- Shifts with imm=15:
  - SLL A=0x789a -> 0x0000.
  - SRL A=0x789a -> 0x0000.
  - SRA A=0x8054 -> 0xFFFF.
  - RL A=0x8754 -> 0x43AA.
- Shift boundaries:
  - imm=0 for each shift op with A=0xA5C3 -> out=0xA5C3.
  - SRA A=0x7000 imm=4 -> 0x0700.
  - RL A=0x8001 imm=1 -> 0x0003.
  - B changes during a shift op do not affect out.
- Back-to-back: change op every cycle across all 8 ops -> each result appears exactly one edge after its inputs, with no bubbles.
